// File: rtl/wvb_wr_addr_ctrl.sv
// wvb_wr_addr_ctrl: write-side address, occupancy and header generator for the waveform buffer ring RAM.
// Splits waveforms into headers of at most P_MAX_LEN words and truncates or drops them on overflow.
module wvb_wr_addr_ctrl #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_MAX_LEN    = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic                    sample_sof,
  input  logic                    sample_eof,
  input  logic [P_DATA_WIDTH-1:0] sample_data,
  input  logic                    hdr_full,
  input  logic                    rel_valid,
  input  logic [P_ADR_WIDTH:0]    rel_len,
  output logic                    wvb_wren,
  output logic [P_ADR_WIDTH-1:0]  wvb_wr_addr,
  output logic [P_DATA_WIDTH-1:0] wvb_wr_data,
  output logic                    hdr_wrreq,
  output logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
  output logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
  output logic                    hdr_partial,
  output logic                    hdr_continued,
  output logic [P_ADR_WIDTH:0]    occupancy,
  output logic [15:0]             ovf_cnt,
  output logic [15:0]             err_cnt
);
  localparam int LW = P_ADR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH = {1'b1, {P_ADR_WIDTH{1'b0}}};
  localparam logic [LW-1:0] MAXL = LW'(P_MAX_LEN);
  localparam logic [LW-1:0] ONE_L = LW'(1);
  localparam logic [P_ADR_WIDTH-1:0] ONE_A = P_ADR_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t r_state, w_state;
  logic [P_ADR_WIDTH-1:0] r_wp, w_wp, r_seg_start, w_seg_start, w_stop;
  logic [LW-1:0] r_len, w_len, w_occ;
  logic [LW:0] w_total, w_rel, w_diff;
  logic r_cont, w_cont, r_split, w_split;
  logic w_wren, w_hdr, w_partial, w_full, w_open, w_extend, w_ovf_inc, w_err_seq, w_err_rel;
  logic [1:0] w_err_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // r_split: the previous word closed a full-length segment, so the next sample opens a continuation
  always_comb begin
    w_state     = r_state;
    w_wp        = r_wp;
    w_seg_start = r_seg_start;
    w_len       = r_len;
    w_cont      = r_cont;
    w_split     = r_split;
    w_wren      = 1'b0;
    w_hdr       = 1'b0;
    w_partial   = 1'b0;
    w_ovf_inc   = 1'b0;
    w_full      = (occupancy == DEPTH);
    w_open      = sample_valid & ((r_state == IDLE & sample_sof) | (r_state == WRITE & r_split));
    w_extend    = sample_valid & (r_state == WRITE) & !r_split;
    w_err_seq   = sample_valid & ((r_state == IDLE) ? !sample_sof : sample_sof);
    if (w_open && (hdr_full || w_full)) begin
      w_ovf_inc = 1'b1;
      w_state   = sample_eof ? IDLE : DROP;
    end else if (w_open) begin
      w_wren      = 1'b1;
      w_seg_start = r_wp;
      w_len       = ONE_L;
      w_cont      = (r_state == WRITE);
    end else if (w_extend && w_full) begin
      w_hdr     = 1'b1;
      w_partial = 1'b1;
      w_ovf_inc = 1'b1;
      w_state   = sample_eof ? IDLE : DROP;
    end else if (w_extend) begin
      w_wren = 1'b1;
      w_len  = r_len + ONE_L;
    end else if (sample_valid && r_state == DROP && sample_eof) begin
      w_state = IDLE;
    end
    w_stop = w_wren ? r_wp : r_wp - ONE_A;
    if (w_wren) begin
      w_wp      = r_wp + ONE_A;
      w_hdr     = sample_eof | (w_len == MAXL);
      w_partial = !sample_eof;
      w_split   = !sample_eof & (w_len == MAXL);
      w_state   = sample_eof ? IDLE : WRITE;
    end
    w_total   = {1'b0, occupancy} + (LW+1)'(w_wren);
    w_rel     = rel_valid ? {1'b0, rel_len} : '0;
    w_err_rel = w_rel > w_total;
    w_diff    = w_total - w_rel;
    w_occ     = w_err_rel ? '0 : w_diff[LW-1:0];
    w_err_inc = {1'b0, w_err_seq} + {1'b0, w_err_rel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wp           <= '0;
      r_seg_start    <= '0;
      r_len          <= '0;
      r_cont         <= 1'b0;
      r_split        <= 1'b0;
      wvb_wren       <= 1'b0;
      wvb_wr_addr    <= '0;
      wvb_wr_data    <= '0;
      hdr_wrreq      <= 1'b0;
      hdr_start_addr <= '0;
      hdr_stop_addr  <= '0;
      hdr_partial    <= 1'b0;
      hdr_continued  <= 1'b0;
      occupancy      <= '0;
      ovf_cnt        <= '0;
      err_cnt        <= '0;
    end else begin
      r_state     <= w_state;
      r_wp        <= w_wp;
      r_seg_start <= w_seg_start;
      r_len       <= w_len;
      r_cont      <= w_cont;
      r_split     <= w_split;
      wvb_wren    <= w_wren;
      hdr_wrreq   <= w_hdr;
      occupancy   <= w_occ;
      ovf_cnt     <= sat_add(ovf_cnt, {1'b0, w_ovf_inc});
      err_cnt     <= sat_add(err_cnt, w_err_inc);
      if (w_wren) begin
        wvb_wr_addr <= r_wp;
        wvb_wr_data <= sample_data;
      end
      if (w_hdr) begin
        hdr_start_addr <= w_seg_start;
        hdr_stop_addr  <= w_stop;
        hdr_partial    <= w_partial;
        hdr_continued  <= w_cont;
      end
    end
  end
endmodule

// File: tb/tb_wvb_wr_addr_ctrl.sv
// tb_wvb_wr_addr_ctrl: directed table, corner-case sequences and random traffic against a
// waveform-level accounting model of the write address controller.
module tb_wvb_wr_addr_ctrl;
  localparam int AW = 12;
  localparam int DW = 22;
  localparam int ML = 8;
  localparam int D = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_valid = 1'b0, sample_sof = 1'b0, sample_eof = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic hdr_full = 1'b0, rel_valid = 1'b0;
  logic [AW:0] rel_len = '0;
  logic wvb_wren, hdr_wrreq, hdr_partial, hdr_continued;
  logic [AW-1:0] wvb_wr_addr, hdr_start_addr, hdr_stop_addr;
  logic [DW-1:0] wvb_wr_data;
  logic [AW:0] occupancy;
  logic [15:0] ovf_cnt, err_cnt;

  wvb_wr_addr_ctrl #(.P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_sof(sample_sof),
    .sample_eof(sample_eof), .sample_data(sample_data), .hdr_full(hdr_full),
    .rel_valid(rel_valid), .rel_len(rel_len), .wvb_wren(wvb_wren), .wvb_wr_addr(wvb_wr_addr),
    .wvb_wr_data(wvb_wr_data), .hdr_wrreq(hdr_wrreq), .hdr_start_addr(hdr_start_addr),
    .hdr_stop_addr(hdr_stop_addr), .hdr_partial(hdr_partial), .hdr_continued(hdr_continued),
    .occupancy(occupancy), .ovf_cnt(ovf_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string n, input int a, input int e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  // Model: words written per segment, ring pointer and occupancy kept as plain integers.
  int m_wp, m_occ, m_ovf, m_err, m_start, m_words;
  bit m_in, m_drop, m_cont;
  bit e_wren, e_hdr, e_part, e_cont;
  int e_addr, e_data, e_start, e_stop;

  task automatic m_reset();
    m_wp = 0; m_occ = 0; m_ovf = 0; m_err = 0; m_start = 0; m_words = 0;
    m_in = 0; m_drop = 0; m_cont = 0;
  endtask

  task automatic hdr_out(input int stop, input bit part);
    e_hdr = 1; e_start = m_start; e_stop = stop; e_part = part; e_cont = m_cont;
  endtask

  task automatic put(input int d, input bit eof);
    e_wren = 1; e_addr = m_wp; e_data = d; m_wp = (m_wp + 1) % D; m_words++;
    if (eof) begin hdr_out(e_addr, 0); m_in = 0; end
    else if (m_words == ML) hdr_out(e_addr, 1);
  endtask

  task automatic open_seg(input int d, input bit eof, input bit hf, input bit cont);
    if (hf || m_occ == D) begin m_ovf++; m_in = 0; m_drop = !eof; end
    else begin m_in = 1; m_start = m_wp; m_words = 0; m_cont = cont; put(d, eof); end
  endtask

  task automatic model(input bit v, sof, eof, input int d, input bit hf, rv, input int rl);
    int total, rel;
    e_wren = 0; e_hdr = 0;
    if (v) begin
      if (m_drop) begin
        if (sof) m_err++;
        if (eof) m_drop = 0;
      end else if (!m_in) begin
        if (!sof) m_err++;
        else open_seg(d, eof, hf, 0);
      end else begin
        if (sof) m_err++;
        if (m_words == ML) open_seg(d, eof, hf, 1);
        else if (m_occ == D) begin
          hdr_out((m_wp + D - 1) % D, 1); m_ovf++; m_in = 0; m_drop = !eof;
        end else put(d, eof);
      end
    end
    total = m_occ + int'(e_wren);
    rel = rv ? rl : 0;
    if (rel > total) begin m_occ = 0; m_err++; end
    else m_occ = total - rel;
    if (m_ovf > 65535) m_ovf = 65535;
    if (m_err > 65535) m_err = 65535;
  endtask

  typedef struct {int s, e; bit p, c;} hdr_t;
  int wq[$];
  hdr_t hq[$];

  task automatic step(input int v, sof, eof, d, hf, rv, rl);
    sample_valid = v[0]; sample_sof = sof[0]; sample_eof = eof[0];
    sample_data = DW'(d); hdr_full = hf[0]; rel_valid = rv[0]; rel_len = (AW+1)'(rl);
    model(v[0], sof[0], eof[0], d, hf[0], rv[0], rl);
    @(posedge clk);
    #1;
    chk("wren", int'(wvb_wren), int'(e_wren));
    if (e_wren) begin
      chk("wr_addr", int'(wvb_wr_addr), e_addr);
      chk("wr_data", int'(wvb_wr_data), e_data);
    end
    chk("hdr_wrreq", int'(hdr_wrreq), int'(e_hdr));
    if (e_hdr) begin
      chk("hdr_start", int'(hdr_start_addr), e_start);
      chk("hdr_stop", int'(hdr_stop_addr), e_stop);
      chk("hdr_partial", int'(hdr_partial), int'(e_part));
      chk("hdr_continued", int'(hdr_continued), int'(e_cont));
    end
    chk("occupancy", int'(occupancy), m_occ);
    chk("ovf_cnt", int'(ovf_cnt), m_ovf);
    chk("err_cnt", int'(err_cnt), m_err);
    if (wvb_wren) wq.push_back(int'(wvb_wr_addr));
    if (hdr_wrreq) hq.push_back('{int'(hdr_start_addr), int'(hdr_stop_addr), hdr_partial, hdr_continued});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wave(input int n, input int rv, input int rl);
    for (int i = 0; i < n; i++) step(1, i == 0, i == n - 1, i + 1, 0, rv, rl);
  endtask

  task automatic do_reset();
    sample_valid = 0; sample_sof = 0; sample_eof = 0; hdr_full = 0; rel_valid = 0;
    rst_n = 0;
    #2;
    chk("rst_wren", int'(wvb_wren), 0);
    chk("rst_wr_addr", int'(wvb_wr_addr), 0);
    chk("rst_wr_data", int'(wvb_wr_data), 0);
    chk("rst_hdr_wrreq", int'(hdr_wrreq), 0);
    chk("rst_hdr_start", int'(hdr_start_addr), 0);
    chk("rst_hdr_stop", int'(hdr_stop_addr), 0);
    chk("rst_hdr_partial", int'(hdr_partial), 0);
    chk("rst_hdr_continued", int'(hdr_continued), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_ovf_cnt", int'(ovf_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    wq.delete();
    hq.delete();
  endtask

  typedef struct {int v, s, e, d, hf, rv, rl, xw, xa, xd, xh, xs, xe, xp, xc, xo;} vec_t;
  vec_t tbl[$];

  task automatic run_table();
    tbl.push_back('{1, 1, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 2, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 3, 0, 0, 0,  1, 2, 3, 0, 0, 0, 0, 0, 3});
    tbl.push_back('{1, 0, 1, 4, 0, 0, 0,  1, 3, 4, 1, 0, 3, 0, 0, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4});
    tbl.push_back('{1, 1, 1, 5, 0, 1, 2,  1, 4, 5, 1, 4, 4, 0, 0, 3});
    tbl.push_back('{1, 1, 0, 6, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3});
    tbl.push_back('{1, 0, 1, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 9,  0, 0, 0, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].hf, tbl[i].rv, tbl[i].rl);
      chk("tbl_wren", int'(wvb_wren), tbl[i].xw);
      if (tbl[i].xw != 0) begin
        chk("tbl_addr", int'(wvb_wr_addr), tbl[i].xa);
        chk("tbl_data", int'(wvb_wr_data), tbl[i].xd);
      end
      chk("tbl_hdr", int'(hdr_wrreq), tbl[i].xh);
      if (tbl[i].xh != 0) begin
        chk("tbl_start", int'(hdr_start_addr), tbl[i].xs);
        chk("tbl_stop", int'(hdr_stop_addr), tbl[i].xe);
        chk("tbl_partial", int'(hdr_partial), tbl[i].xp);
        chk("tbl_cont", int'(hdr_continued), tbl[i].xc);
      end
      chk("tbl_occ", int'(occupancy), tbl[i].xo);
    end
    chk("tbl_ovf_total", int'(ovf_cnt), 1);
    chk("tbl_err_total", int'(err_cnt), 1);
  endtask

  task automatic run_random();
    int n, v, s;
    for (int w = 0; w < 200; w++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; ) begin
        v = ($urandom_range(0, 3) != 0) ? 1 : 0;
        s = (i == 0) ? int'($urandom_range(0, 15) != 0) : int'($urandom_range(0, 30) == 0);
        step(v, s, int'(i == n - 1), int'($urandom_range(0, (1 << DW) - 1)),
             int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 12)));
        i += v;
      end
      idle(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #1;
    do_reset();
    run_table();

    do_reset();
    wave(4, 0, 0);
    chk("basic_nwr", wq.size(), 4);
    chk("basic_addr3", wq[3], 3);
    chk("basic_nhdr", hq.size(), 1);
    chk("basic_stop", hq[0].e, 3);
    chk("basic_occ", int'(occupancy), 4);

    do_reset();
    wave(20, 0, 0);
    chk("split_nhdr", hq.size(), 3);
    chk("split0", hq[0].s * 100 + hq[0].e * 4 + 2 * int'(hq[0].p) + int'(hq[0].c), 0 * 100 + 7 * 4 + 2);
    chk("split1", hq[1].s * 100 + hq[1].e * 4 + 2 * int'(hq[1].p) + int'(hq[1].c), 8 * 100 + 15 * 4 + 3);
    chk("split2", hq[2].s * 100 + hq[2].e * 4 + 2 * int'(hq[2].p) + int'(hq[2].c), 16 * 100 + 19 * 4 + 1);
    chk("split_occ", int'(occupancy), 20);

    do_reset();
    wave(4094, 1, 1);
    wq.delete(); hq.delete();
    wave(4, 0, 0);
    chk("wrap_nwr", wq.size(), 4);
    chk("wrap_a0", wq[0], 4094);
    chk("wrap_a1", wq[1], 4095);
    chk("wrap_a2", wq[2], 0);
    chk("wrap_a3", wq[3], 1);
    chk("wrap_nhdr", hq.size(), 1);
    chk("wrap_start", hq[0].s, 4094);
    chk("wrap_stop", hq[0].e, 1);

    do_reset();
    wave(4095, 0, 0);
    chk("fill_occ", int'(occupancy), 4095);
    wq.delete(); hq.delete();
    wave(3, 0, 0);
    chk("full_nwr", wq.size(), 1);
    chk("full_addr", wq[0], 4095);
    chk("full_nhdr", hq.size(), 1);
    chk("full_start", hq[0].s, 4095);
    chk("full_stop", hq[0].e, 4095);
    chk("full_partial", int'(hq[0].p), 1);
    chk("full_ovf", int'(ovf_cnt), 1);
    chk("full_occ", int'(occupancy), 4096);
    wave(2, 0, 0);
    chk("full_drop_nwr", wq.size(), 1);
    chk("full_drop_ovf", int'(ovf_cnt), 2);

    do_reset();
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 2, 0, 0, 0);
    step(1, 0, 1, 3, 0, 0, 0);
    chk("hf_nwr", wq.size(), 0);
    chk("hf_nhdr", hq.size(), 0);
    chk("hf_ovf", int'(ovf_cnt), 1);
    step(1, 1, 1, 9, 0, 0, 0);
    chk("single_nhdr", hq.size(), 1);
    chk("single_start", hq[0].s, 0);
    chk("single_stop", hq[0].e, 0);
    wave(9, 0, 0);
    chk("rel_pre_occ", int'(occupancy), 10);
    step(1, 1, 1, 5, 0, 1, 4);
    chk("rel_occ", int'(occupancy), 7);

    step(1, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 2, 0, 0, 0);
    do_reset();
    idle(3);
    chk("midrst_nhdr", hq.size(), 0);

    do_reset();
    run_random();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wvb_wr_addr_ctrl.md
Name: wvb_wr_addr_ctrl

Overview:
Write-side address controller for the mDOM waveform buffer circular RAM. It takes the qualified sample stream, generates RAM write address, enable and data, and tracks buffer occupancy against words released by the read side. For each waveform segment it issues one header-FIFO write carrying start/stop addresses and partial/continued flags; those headers later drive the read-address controller. Segments that overflow the buffer or arrive while the header FIFO is full are truncated or dropped.

Parameters:
P_ADR_WIDTH, 12, waveform RAM address width; depth D = 2^P_ADR_WIDTH words.
P_DATA_WIDTH, 22, sample word width.
P_MAX_LEN, 512, maximum words per header segment (1..D).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
sample_valid  in  1  sample qualifier.
sample_sof  in  1  first sample of waveform (valid with sample_valid).
sample_eof  in  1  last sample of waveform (valid with sample_valid; may coincide with sof).
sample_data  in  P_DATA_WIDTH  sample word.
hdr_full  in  1  header FIFO full.
rel_valid  in  1  read side released a waveform segment.
rel_len  in  P_ADR_WIDTH+1  words released with rel_valid.
wvb_wren  out  1  RAM write enable.
wvb_wr_addr  out  P_ADR_WIDTH  RAM write address.
wvb_wr_data  out  P_DATA_WIDTH  RAM write data.
hdr_wrreq  out  1  header FIFO write strobe.
hdr_start_addr  out  P_ADR_WIDTH  first address of segment.
hdr_stop_addr  out  P_ADR_WIDTH  last address of segment.
hdr_partial  out  1  segment does not end the waveform.
hdr_continued  out  1  segment continues an earlier segment.
occupancy  out  P_ADR_WIDTH+1  words held in RAM (0..D).
ovf_cnt  out  16  dropped/truncated waveform count, saturating.
err_cnt  out  16  protocol error count, saturating.

Behaviour:
- Async reset (rst_n low): all outputs 0, internal next-write pointer wp = 0, state IDLE, segment length 0. Reset mid-waveform discards it, no header.
- Latency: sample accepted in cycle t -> wvb_wren/addr/data registered at t+1; closing header's hdr_wrreq in the same t+1 cycle. All outputs registered; strobes one cycle wide.
- wp increments mod D per written word (wraps 2^N-1 -> 0); start/stop addresses may straddle wrap.
- full = (occupancy == D). occupancy next = occupancy + write - (rel_valid ? rel_len : 0), computed jointly for simultaneous events. Release exceeding occupancy clamps to 0 and increments err_cnt.
- States IDLE, WRITE, DROP:
- IDLE: sample_valid & !sof -> ignored, err_cnt++. sample_valid & sof: if hdr_full or full -> ovf_cnt++, go DROP (IDLE if eof). Else write at wp, latch seg_start = wp, len = 1, continued = 0; if eof -> header (start=stop=wp, partial 0), stay IDLE; else WRITE.
- WRITE, sample_valid: sof set -> err_cnt++, sample treated as ordinary. If full -> no write, header (stop = last written addr, partial 1), ovf_cnt++, go DROP (IDLE if eof). Else write, len++; eof -> header (partial 0), IDLE; else len == P_MAX_LEN -> header (partial 1), next sample opens new segment with continued = 1.
- Segment opening after a P_MAX_LEN split re-checks hdr_full/full as at sof; failure -> ovf_cnt++, DROP, no header.
- Header slot reserved at segment open: hdr_full is not checked when closing a segment.
- hdr_continued = 1 on every segment after the first of a waveform.
- DROP: discard samples until sample_valid & eof -> IDLE. sof in DROP -> err_cnt++, ignored.
- Counters saturate at 16'hFFFF.

Test Plan:
- Reset, 4-sample waveform (data 1..4) -> wren at addrs 0..3 with data 1..4; one header start 0, stop 3, partial 0, continued 0; occupancy 4.
- P_MAX_LEN=8, 20-sample waveform -> headers (0,7,p1,c0), (8,15,p1,c1), (16,19,p0,c1); occupancy 20.
- wp preset to 4094 via prior writes, 4-sample waveform -> addrs 4094,4095,0,1; header start 4094, stop 1.
- occupancy 4095, no release, 3-sample waveform -> one write; header stop = that addr, partial 1; ovf_cnt 1; occupancy 4096; next waveform dropped, ovf_cnt 2, no wren.
- hdr_full at sof -> no wren, no hdr_wrreq, ovf_cnt +1; 1-sample sof&eof waveform -> header start = stop.
- rel_valid with rel_len 4 same cycle as a write, occupancy 10 -> occupancy 7; rst_n low mid-waveform -> all outputs 0, no header.
